ucisc_mem_arbiter: RTL and testbench

- Shares the single-port main memory between the uCISC CPU and one device requester (DMA/debug loader).
- Sits between the CPU's memory port, the device bus and the block RAM.
- Grants one access per cycle. The CPU has priority; a saturating starvation counter bounds device wait.
- A denied CPU request is a stall: the CPU must hold its `step` and request until granted.

---
 rtl/ucisc_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_ucisc_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ucisc_mem_arbiter.sv
// rtl/ucisc_mem_arbiter.sv - CPU/device single-port memory arbiter, CPU priority with starvation bound.
// Optional device burst lock enabled by defining UCISC_ARBITER_LOCK_EN.
module ucisc_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clock_input,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  dev_req,
  input  logic                  dev_we,
  input  logic [ADDR_WIDTH-1:0] dev_addr,
  input  logic [DATA_WIDTH-1:0] dev_wdata,
  output logic                  dev_gnt,
  output logic [DATA_WIDTH-1:0] dev_rdata,
  output logic                  dev_rvalid,
  input  logic                  dev_lock,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DEV  = 2'd2
  } rd_owner_e;

  rd_owner_e  rd_owner_q, rd_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       starve_hit;
  logic       lock_hold;
  logic       cpu_block;

`ifdef UCISC_ARBITER_LOCK_EN
  logic lock_owner_q, lock_owner_d;

  // A raised dev_lock wins contention; once owned, the CPU is shut out until dev_lock drops.
  assign lock_hold = dev_lock;
  assign cpu_block = lock_owner_q & dev_lock;

  always_comb begin
    lock_owner_d = lock_owner_q;
    if (!dev_lock) begin
      lock_owner_d = 1'b0;
    end else if (dev_gnt) begin
      lock_owner_d = 1'b1;
    end
  end

  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      lock_owner_q <= 1'b0;
    end else begin
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  logic unused_dev_lock;

  assign unused_dev_lock = dev_lock;
  assign lock_hold       = 1'b0;
  assign cpu_block       = 1'b0;
`endif

  assign starve_hit = (starve_cnt_q == LIMIT);

  // Grants are masked while reset is held so every output reads 0 during reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dev_gnt = 1'b0;
    if (reset) begin
      if (cpu_req && !cpu_block && !(dev_req && (starve_hit || lock_hold))) begin
        cpu_gnt = 1'b1;
      end else if (dev_req) begin
        dev_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | dev_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dev_gnt) begin
      mem_we    = dev_we;
      mem_addr  = dev_addr;
      mem_wdata = dev_wdata;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dev_req || dev_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (cpu_gnt && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rd_owner_d = RD_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = RD_CPU;
    end else if (dev_gnt && !dev_we) begin
      rd_owner_d = RD_DEV;
    end
  end

  always_ff @(posedge clock_input or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= 4'd0;
      rd_owner_q   <= RD_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign cpu_rvalid = (rd_owner_q == RD_CPU);
  assign dev_rvalid = (rd_owner_q == RD_DEV);
  assign cpu_rdata  = mem_rdata;
  assign dev_rdata  = mem_rdata;

endmodule

// File: tb/tb_ucisc_mem_arbiter.sv
// tb/tb_ucisc_mem_arbiter.sv - directed self-checking bench for ucisc_mem_arbiter.
module tb_ucisc_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dev_req, dev_we, dev_lock;
  logic [15:0] cpu_addr, cpu_wdata, dev_addr, dev_wdata;
  logic        cpu_gnt, cpu_rvalid, dev_gnt, dev_rvalid;
  logic [15:0] cpu_rdata, dev_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  ucisc_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(3)) dut (
    .clock_input(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_gnt(dev_gnt), .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid),
    .dev_lock(dev_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; dev_req = 0; dev_we = 0; dev_lock = 0;
    cpu_addr = 0; cpu_wdata = 0; dev_addr = 0; dev_wdata = 0;
  endtask

  logic [7:0]  pat;
  logic [11:0] sreq_c, sreq_d, sexp_d;
  logic [5:0]  lexp_d;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'h07FF;
    mem[16'h0000] = 16'h1234;
    mem_rdata = 16'h0000;
    idle();
    reset = 0;
    cpu_req = 1; cpu_addr = 16'h0010;
    #2;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dev_gnt", dev_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dev_rvalid", dev_rvalid, 0);
    cyc(); cyc();

    // CPU read of 0x0010
    reset = 1;
    #1;
    chk("rd_cpu_gnt", cpu_gnt, 1);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_addr", mem_addr, 16'h0010);
    chk("rd_mem_we", mem_we, 0);
    cyc();
    cpu_req = 0;
    #1;
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_cpu_rdata", cpu_rdata, 16'h07FF);
    chk("rd_dev_rvalid", dev_rvalid, 0);

    // contention, both requesting continuously
    pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      cpu_req = 1; cpu_addr = 16'h0000;
      dev_req = 1; dev_addr = 16'h0010;
      #1;
      chk($sformatf("cont_dev_gnt_%0d", i), dev_gnt, pat[i]);
      chk($sformatf("cont_cpu_gnt_%0d", i), cpu_gnt, !pat[i]);
      chk($sformatf("cont_excl_%0d", i), cpu_gnt & dev_gnt, 0);
      if (i > 0) begin
        chk($sformatf("cont_cpu_rvalid_%0d", i), cpu_rvalid, !pat[i-1]);
        chk($sformatf("cont_dev_rvalid_%0d", i), dev_rvalid, pat[i-1]);
        if (pat[i-1]) chk($sformatf("cont_dev_rdata_%0d", i), dev_rdata, 16'h07FF);
        else          chk($sformatf("cont_cpu_rdata_%0d", i), cpu_rdata, 16'h1234);
      end
    end
    cyc();
    idle();
    #1;
    chk("cont_tail_dev_rvalid", dev_rvalid, 1);
    chk("cont_tail_dev_rdata", dev_rdata, 16'h07FF);
    chk("cont_tail_cpu_rvalid", cpu_rvalid, 0);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_mem_addr", mem_addr, 0);

    // device write while CPU idle, then CPU reads it back
    cyc();
    dev_req = 1; dev_we = 1; dev_addr = 16'h0100; dev_wdata = 16'hFFFE;
    #1;
    chk("dw_dev_gnt", dev_gnt, 1);
    chk("dw_cpu_gnt", cpu_gnt, 0);
    chk("dw_mem_we", mem_we, 1);
    chk("dw_mem_addr", mem_addr, 16'h0100);
    chk("dw_mem_wdata", mem_wdata, 16'hFFFE);
    cyc();
    idle();
    cpu_req = 1; cpu_addr = 16'h0100;
    #1;
    chk("dw_dev_rvalid", dev_rvalid, 0);
    chk("dw_mem_we_after", mem_we, 0);
    chk("dw_rb_cpu_gnt", cpu_gnt, 1);
    cyc();
    idle();
    #1;
    chk("dw_rb_cpu_rvalid", cpu_rvalid, 1);
    chk("dw_rb_cpu_rdata", cpu_rdata, 16'hFFFE);
    chk("dw_rb_dev_rvalid", dev_rvalid, 0);

    // starvation counter: clear on dev_req drop, saturation with no CPU request
    // step order is bit 0 first
    sreq_c = 12'b1111_0111_1111;
    sreq_d = 12'b1111_1111_1011;
    sexp_d = 12'b0000_1000_1000;
    sreq_c[8] = 0;
    sexp_d[8] = 1;
    sexp_d[6] = 1;
    sexp_d[3] = 0;
    for (int i = 0; i < 11; i++) begin
      cyc();
      idle();
      cpu_req = sreq_c[i];
      dev_req = sreq_d[i];
      #1;
      chk($sformatf("starve_dev_gnt_%0d", i), dev_gnt, sexp_d[i]);
      chk($sformatf("starve_cpu_gnt_%0d", i), cpu_gnt, sreq_c[i] & !sexp_d[i]);
    end
    cyc();
    idle();
    #1;

    // reset asserted between a read grant and its data edge
    cyc();
    cpu_req = 1; cpu_addr = 16'h0010;
    #1;
    chk("mr_cpu_gnt", cpu_gnt, 1);
    #1;
    reset = 0;
    #1;
    chk("mr_rst_cpu_gnt", cpu_gnt, 0);
    chk("mr_rst_mem_en", mem_en, 0);
    chk("mr_rst_mem_addr", mem_addr, 0);
    cyc();
    chk("mr_cpu_rvalid", cpu_rvalid, 0);
    chk("mr_dev_rvalid", dev_rvalid, 0);
    reset = 1;
    cpu_addr = 16'h0000;
    #1;
    chk("mr_post_cpu_rvalid", cpu_rvalid, 0);
    chk("mr_post_cpu_gnt", cpu_gnt, 1);
    cyc();
    idle();
    #1;
    chk("mr_post_rvalid", cpu_rvalid, 1);
    chk("mr_post_rdata", cpu_rdata, 16'h1234);

    // dev_lock held for 5 cycles, both requesting
`ifdef UCISC_ARBITER_LOCK_EN
    lexp_d = 6'b01_1111;
`else
    lexp_d = 6'b00_1000;
`endif
    cyc();
    idle();
    for (int i = 0; i < 6; i++) begin
      cyc();
      cpu_req = 1; dev_req = 1;
      dev_lock = (i < 5);
      #1;
      chk($sformatf("lock_dev_gnt_%0d", i), dev_gnt, lexp_d[i]);
      chk($sformatf("lock_cpu_gnt_%0d", i), cpu_gnt, !lexp_d[i]);
    end
    cyc();
    idle();
    #1;
    chk("end_mem_en", mem_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
